// File: rtl/qmult_seq.sv
// Iterative shift-add multiplier for sign-magnitude Q-format words.
// One multiplier bit per clock; the product saturates instead of wrapping.
module qmult_seq #(
   parameter int Q = 9,
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   output logic         valid,
   output logic         busy,
   output logic         ovf
);

   localparam int AW = 2*N-2;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N-2);

   typedef enum logic {S_IDLE, S_CALC} state_t;

   state_t          r_state;
   logic [N-2:0]    r_mag_a;
   logic [N-2:0]    r_mag_b;
   logic            r_sgn;
   logic [AW-1:0]   r_acc;
   logic [CW-1:0]   r_cnt;

   logic [AW-1:0]   w_addend;
   logic [AW-1:0]   w_acc_next;
   logic [AW-Q-1:0] w_p;
   logic            w_sat;
   logic [N-2:0]    w_mag;

   // The final bit step and result formation share one edge, so the
   // result is built from the accumulator value that includes that step.
   always_comb begin
      w_addend   = r_mag_b[r_cnt] ? ({{(N-1){1'b0}}, r_mag_a} << r_cnt) : '0;
      w_acc_next = r_acc + w_addend;
      w_p        = w_acc_next[AW-1:Q];
      w_sat      = |w_p[AW-Q-1:N-1];
      w_mag      = w_sat ? '1 : w_p[N-2:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_sgn   <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
         c       <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mag_a <= a[N-2:0];
                  r_mag_b <= b[N-2:0];
                  r_sgn   <= a[N-1] ^ b[N-1];
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  // zero magnitude never carries a sign
                  c       <= {r_sgn & (|w_mag), w_mag};
                  ovf     <= w_sat;
                  valid   <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qmult_seq.sv
// Bench for qmult_seq: arithmetic reference model with per-cycle compare,
// directed spec vectors and randomized start/reset traffic.
module tb_qmult_seq;

   localparam int Q = 9;
   localparam int N = 16;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a     = '0;
   logic [N-1:0] b     = '0;
   logic [N-1:0] c;
   logic         valid, busy, ovf;

   int errors = 0;
   int checks = 0;

   qmult_seq #(.Q(Q), .N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .c(c), .valid(valid), .busy(busy), .ovf(ovf)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: integer product of magnitudes, truncate Q bits, saturate.
   function automatic logic [N-1:0] mdl(input logic [N-1:0] x, input logic [N-1:0] y,
                                        output logic o);
      longint unsigned p;
      logic [N-1:0] r;
      p = (longint'(x[N-2:0]) * longint'(y[N-2:0])) / (longint'(1) << Q);
      if (p > ((longint'(1) << (N-1)) - 1)) begin
         r[N-2:0] = '1;
         o = 1'b1;
      end else begin
         r[N-2:0] = p[N-2:0];
         o = 1'b0;
      end
      r[N-1] = (x[N-1] ^ y[N-1]) && (r[N-2:0] != 0);
      return r;
   endfunction

   // Timeline model: accept, count N-1 edges, then publish.
   bit           pend = 0, m_valid = 0, m_busy = 0, m_ovf = 0, e_ovf = 0;
   logic         e_o;
   logic [N-1:0] m_c = '0, e_c = '0;
   int           left = 0;

   always @(posedge clk) begin
      if (rst) begin
         pend = 0; m_valid = 0; m_busy = 0; m_c = '0; m_ovf = 0;
      end else begin
         m_valid = 0;
         if (pend) begin
            left--;
            if (left == 0) begin
               pend = 0; m_busy = 0; m_valid = 1; m_c = e_c; m_ovf = e_ovf;
            end
         end else if (start) begin
            pend = 1; m_busy = 1; left = N-1;
            e_c = mdl(a, b, e_o);
            e_ovf = e_o;
         end
      end
   end

   always @(negedge clk) begin
      chk("valid", {15'b0, valid}, {15'b0, m_valid});
      chk("busy",  {15'b0, busy},  {15'b0, m_busy});
      chk("c",     c,              m_c);
      chk("ovf",   {15'b0, ovf},   {15'b0, m_ovf});
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [N-1:0] rnd_op();
      logic [N-1:0] v;
      v = N'($urandom);
      v[N-2:0] = v[N-2:0] >> $urandom_range(0, 14);
      return v;
   endfunction

   // Starts a multiply from the current negedge and waits for its result.
   task automatic run_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] expc, input logic expo);
      int n;
      start = 1'b1; a = x; b = y;
      tick();
      start = 1'b0; a = rnd_op(); b = rnd_op();
      n = 0;
      while (!valid && n < 40) begin
         tick();
         n++;
      end
      chk("latency", N'(n), N'(15));
      chk("dir_c", c, expc);
      chk("dir_ovf", {15'b0, ovf}, {15'b0, expo});
   endtask

   initial begin
      logic o;
      logic [N-1:0] r;
      int n, vcnt;

      tick();
      tick();
      rst = 1'b0;
      chk("rst_c", c, 16'h0000);
      chk("rst_busy", {15'b0, busy}, 16'h0000);
      chk("rst_valid", {15'b0, valid}, 16'h0000);
      chk("rst_ovf", {15'b0, ovf}, 16'h0000);

      // hand-computed pins for the model
      r = mdl(16'h0200, 16'h0200, o); chk("pin1", r, 16'h0200); chk("pin1o", {15'b0, o}, 16'h0);
      r = mdl(16'h8300, 16'h0400, o); chk("pin2", r, 16'h8600);
      r = mdl(16'h8000, 16'h0300, o); chk("pin3", r, 16'h0000);
      r = mdl(16'h7FFF, 16'h7FFF, o); chk("pin4", r, 16'h7FFF); chk("pin4o", {15'b0, o}, 16'h1);
      r = mdl(16'hFFFF, 16'h7FFF, o); chk("pin5", r, 16'hFFFF);
      r = mdl(16'h0001, 16'h0001, o); chk("pin6", r, 16'h0000);
      r = mdl(16'h0003, 16'h0300, o); chk("pin7", r, 16'h0004);

      run_mul(16'h0200, 16'h0200, 16'h0200, 1'b0);
      run_mul(16'h8300, 16'h0400, 16'h8600, 1'b0);
      run_mul(16'h8000, 16'h0300, 16'h0000, 1'b0);
      run_mul(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
      run_mul(16'hFFFF, 16'h7FFF, 16'hFFFF, 1'b1);
      run_mul(16'h0001, 16'h0001, 16'h0000, 1'b0);
      run_mul(16'h0003, 16'h0300, 16'h0004, 1'b0);
      run_mul(16'h0000, 16'h8000, 16'h0000, 1'b0);
      tick();

      // ignored start while busy, then back-to-back start in the valid cycle
      start = 1'b1; a = 16'h0200; b = 16'h0400;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1; a = 16'h7FFF; b = 16'h7FFF;
      tick();
      start = 1'b0;
      n = 0;
      while (!valid && n < 40) begin
         tick();
         n++;
      end
      chk("b2b_lat", N'(n), N'(10));
      chk("b2b_c", c, 16'h0400);
      chk("b2b_ovf", {15'b0, ovf}, 16'h0);
      run_mul(16'h8300, 16'h0400, 16'h8600, 1'b0);
      tick();

      // reset in the middle of a multiply
      start = 1'b1; a = 16'h0400; b = 16'h0400;
      tick();
      start = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {15'b0, busy}, 16'h0);
      chk("abort_c", c, 16'h0000);
      chk("abort_ovf", {15'b0, ovf}, 16'h0);
      vcnt = 0;
      repeat (20) begin
         tick();
         if (valid) vcnt++;
      end
      chk("abort_novalid", N'(vcnt), N'(0));
      run_mul(16'h0400, 16'h0400, 16'h0800, 1'b0);
      tick();

      // reset and start together: start dropped
      rst = 1'b1; start = 1'b1; a = 16'h0200; b = 16'h0200;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", {15'b0, busy}, 16'h0);
      tick();
      chk("rst_start_busy2", {15'b0, busy}, 16'h0);

      // random traffic, checked every cycle against the model
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 3) == 0);
         a     = rnd_op();
         b     = rnd_op();
         tick();
      end
      rst = 1'b0; start = 1'b0;
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
